// File: rtl/btn_debounce_n.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// btn_debounce_n
// N-channel push-button conditioner. Each channel gets a 2-FF synchroniser,
// millisecond-granular debounce, one-cycle press/release pulses, a long-press
// pulse and optional auto-repeat. One millisecond prescaler is shared by all
// channels.
//
// Optional feature macro: BTN_DEBOUNCE_REPEAT_EN
//   defined     -> per-channel repeat counter present, repeat_pulse active
//   not defined -> repeat counter removed, repeat_pulse tied to 0
//
// Ports:
//   clk           in   1  system clock
//   rst_n         in   1  asynchronous active-low reset
//   btn           in   N  raw asynchronous button inputs
//   level         out  N  debounced state, 1 = pressed
//   press         out  N  one-cycle pulse on debounced 0->1
//   release_pulse out  N  one-cycle pulse on debounced 1->0
//   long_press    out  N  one-cycle pulse, once per hold, after LONG_MS
//   repeat_pulse  out  N  one-cycle auto-repeat pulse
// The release/repeat outputs carry a _pulse suffix because "release" and
// "repeat" are reserved words in SystemVerilog.
// -----------------------------------------------------------------------------
module btn_debounce_n #(
  parameter int N          = 2,
  parameter int CLK_HZ     = 27_000_000,
  parameter int MS         = 80,
  parameter int LONG_MS    = 1000,
  parameter int REPEAT_MS  = 200,
  parameter int ACTIVE_LOW = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] btn,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] long_press,
  output logic [N-1:0] repeat_pulse
);

  localparam int P  = CLK_HZ / 1000;
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int DW = $clog2(MS + 1);
  localparam int HW = $clog2(LONG_MS + 1);

  localparam logic [PW-1:0] P_ZERO = PW'(0);
  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [PW-1:0] P_LAST = PW'(P - 1);
  localparam logic [DW-1:0] D_ZERO = DW'(0);
  localparam logic [DW-1:0] D_ONE  = DW'(1);
  localparam logic [DW-1:0] D_LAST = DW'(MS - 1);
  localparam logic [HW-1:0] H_ZERO = HW'(0);
  localparam logic [HW-1:0] H_ONE  = HW'(1);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_MS - 1);
  localparam logic [HW-1:0] H_MAX  = HW'(LONG_MS);

  // Reject parameter sets that would make a counter compare value meaningless.
  generate
    if (N < 1 || P < 1 || MS < 1 || LONG_MS < 1 || REPEAT_MS < 1) begin : g_bad_cfg
      $error("btn_debounce_n: illegal parameter set");
    end
  endgenerate

  logic [N-1:0]    in_s;
  logic [N-1:0]    s0_r;
  logic [N-1:0]    s1_r;
  logic [PW-1:0]   pcnt_r;
  logic            ms_stb_r;

  logic [DW-1:0]   dcnt_r    [N];
  logic [DW-1:0]   dcnt_nx_s [N];
  logic [HW-1:0]   hcnt_r    [N];
  logic [HW-1:0]   hcnt_nx_s [N];
  logic [N-1:0]    level_r;
  logic [N-1:0]    level_nx_s;
  logic [N-1:0]    press_r;
  logic [N-1:0]    press_nx_s;
  logic [N-1:0]    rel_r;
  logic [N-1:0]    rel_nx_s;
  logic [N-1:0]    long_r;
  logic [N-1:0]    long_nx_s;

  // Normalise polarity so that 1 always means "pressed".
  assign in_s = (ACTIVE_LOW != 0) ? ~btn : btn;

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_r <= {N{1'b0}};
      s1_r <= {N{1'b0}};
    end else begin
      s0_r <= in_s;
      s1_r <= s0_r;
    end
  end

  // Shared millisecond prescaler; strobe is registered one cycle after wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_r   <= P_ZERO;
      ms_stb_r <= 1'b0;
    end else begin
      if (pcnt_r == P_LAST) begin
        pcnt_r <= P_ZERO;
      end else begin
        pcnt_r <= pcnt_r + P_ONE;
      end
      ms_stb_r <= (pcnt_r == P_LAST);
    end
  end

  // Per-channel debounce and hold next-state logic.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      dcnt_nx_s[i]  = dcnt_r[i];
      level_nx_s[i] = level_r[i];
      press_nx_s[i] = 1'b0;
      rel_nx_s[i]   = 1'b0;
      hcnt_nx_s[i]  = hcnt_r[i];
      long_nx_s[i]  = 1'b0;

      // Any return of the synchronised input to the accepted level discards
      // the partial count, so only an unbroken MS-long difference is accepted.
      if (s1_r[i] == level_r[i]) begin
        dcnt_nx_s[i] = D_ZERO;
      end else if (ms_stb_r) begin
        if (dcnt_r[i] == D_LAST) begin
          level_nx_s[i] = s1_r[i];
          dcnt_nx_s[i]  = D_ZERO;
          press_nx_s[i] = s1_r[i];
          rel_nx_s[i]   = ~s1_r[i];
        end else begin
          dcnt_nx_s[i] = dcnt_r[i] + D_ONE;
        end
      end else begin
        dcnt_nx_s[i] = dcnt_r[i];
      end

      // Hold counter saturates at LONG_MS; a release on the same strobe
      // suppresses the long pulse because the button is already up.
      if (!level_r[i]) begin
        hcnt_nx_s[i] = H_ZERO;
      end else if (ms_stb_r && (hcnt_r[i] < H_MAX)) begin
        hcnt_nx_s[i] = hcnt_r[i] + H_ONE;
        long_nx_s[i] = (hcnt_r[i] == H_LAST) & ~rel_nx_s[i];
      end else begin
        hcnt_nx_s[i] = hcnt_r[i];
      end
    end
  end

  // Per-channel debounce/hold state and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        dcnt_r[i] <= D_ZERO;
        hcnt_r[i] <= H_ZERO;
      end
      level_r <= {N{1'b0}};
      press_r <= {N{1'b0}};
      rel_r   <= {N{1'b0}};
      long_r  <= {N{1'b0}};
    end else begin
      for (int i = 0; i < N; i++) begin
        dcnt_r[i] <= dcnt_nx_s[i];
        hcnt_r[i] <= hcnt_nx_s[i];
      end
      level_r <= level_nx_s;
      press_r <= press_nx_s;
      rel_r   <= rel_nx_s;
      long_r  <= long_nx_s;
    end
  end

`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam int RW = $clog2(REPEAT_MS + 1);
  localparam logic [RW-1:0] R_ZERO = RW'(0);
  localparam logic [RW-1:0] R_ONE  = RW'(1);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_MS - 1);

  logic [RW-1:0] rcnt_r    [N];
  logic [RW-1:0] rcnt_nx_s [N];
  logic [N-1:0]  rpt_r;
  logic [N-1:0]  rpt_nx_s;

  // Auto-repeat runs only once the hold counter has saturated.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      rcnt_nx_s[i] = rcnt_r[i];
      rpt_nx_s[i]  = 1'b0;
      if (!level_r[i] || (hcnt_r[i] < H_MAX)) begin
        rcnt_nx_s[i] = R_ZERO;
      end else if (ms_stb_r) begin
        if (rcnt_r[i] == R_LAST) begin
          rcnt_nx_s[i] = R_ZERO;
          rpt_nx_s[i]  = ~rel_nx_s[i];
        end else begin
          rcnt_nx_s[i] = rcnt_r[i] + R_ONE;
        end
      end else begin
        rcnt_nx_s[i] = rcnt_r[i];
      end
    end
  end

  // Repeat counter and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        rcnt_r[i] <= R_ZERO;
      end
      rpt_r <= {N{1'b0}};
    end else begin
      for (int i = 0; i < N; i++) begin
        rcnt_r[i] <= rcnt_nx_s[i];
      end
      rpt_r <= rpt_nx_s;
    end
  end

  assign repeat_pulse = rpt_r;
`else
  assign repeat_pulse = {N{1'b0}};
`endif

  assign level         = level_r;
  assign press         = press_r;
  assign release_pulse = rel_r;
  assign long_press    = long_r;

endmodule

// File: tb/tb_btn_debounce_n.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_btn_debounce_n
// Directed bench for btn_debounce_n with P=10 clocks/ms, MS=3, LONG_MS=10,
// REPEAT_MS=4, N=2, active-low buttons. Inputs change right after a falling
// edge; outputs are sampled on falling edges. cyc counts rising edges.
// -----------------------------------------------------------------------------
module tb_btn_debounce_n;

  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn;
  logic [N-1:0] level;
  logic [N-1:0] press;
  logic [N-1:0] release_pulse;
  logic [N-1:0] long_press;
  logic [N-1:0] repeat_pulse;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int press_cyc = 0;

  btn_debounce_n #(
    .N(2), .CLK_HZ(10_000), .MS(3), .LONG_MS(10), .REPEAT_MS(4), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn(btn),
    .level(level),
    .press(press),
    .release_pulse(release_pulse),
    .long_press(long_press),
    .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic test_reset();
    rst_n = 1'b0;
    btn   = 2'b11;
    repeat (3) @(negedge clk);
    total++;
    if ({level, press, release_pulse, long_press, repeat_pulse} !== 10'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 0", {level, press, release_pulse, long_press, repeat_pulse});
    end
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    total++;
    if (level !== 2'b00 || press !== 2'b00) begin
      bad++;
      $display("FAIL idle_after_reset: level=%b press=%b want 00/00", level, press);
    end
  endtask

  task automatic test_bounce();
    int pc;
    int lv;
    pc = 0;
    lv = 0;
    btn[0] = 1'b0;
    repeat (15) begin @(negedge clk); pc += press[0]; lv += level[0]; end
    btn[0] = 1'b1;
    repeat (5) begin @(negedge clk); pc += press[0]; lv += level[0]; end
    btn[0] = 1'b0;
    repeat (15) begin @(negedge clk); pc += press[0]; lv += level[0]; end
    btn[0] = 1'b1;
    repeat (40) begin @(negedge clk); pc += press[0]; lv += level[0]; end
    total++;
    if (pc !== 0) begin
      bad++;
      $display("FAIL bounce_press: got %0d pulses want 0", pc);
    end
    total++;
    if (lv !== 0) begin
      bad++;
      $display("FAIL bounce_level: level high for %0d cycles want 0", lv);
    end
  endtask

  task automatic test_clean_press();
    int start;
    int first;
    int cnt;
    int rel;
    start = cyc;
    first = 0;
    cnt = 0;
    rel = 0;
    btn[0] = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (press[0]) begin
        cnt++;
        if (first == 0) begin
          first = cyc - start;
          press_cyc = cyc;
          total++;
          if (level[0] !== 1'b1) begin
            bad++;
            $display("FAIL press_level_edge: level=%b want 1", level[0]);
          end
        end
      end
      rel += release_pulse[0];
    end
    total++;
    if (cnt !== 1) begin
      bad++;
      $display("FAIL press_count: got %0d want 1", cnt);
    end
    total++;
    if (first < 21 || first > 33) begin
      bad++;
      $display("FAIL press_latency: got %0d want 21..33", first);
    end
    total++;
    if (rel !== 0 || level[0] !== 1'b1) begin
      bad++;
      $display("FAIL press_hold_state: release=%0d level=%b want 0/1", rel, level[0]);
    end
  endtask

  task automatic test_long_hold();
    int lp_cnt;
    int lp_cyc;
    int rp_cnt;
    int pr_cnt;
    int last_rp;
    int want;
    lp_cnt = 0;
    lp_cyc = 0;
    rp_cnt = 0;
    pr_cnt = 0;
    last_rp = 0;
    want = 0;
    while (cyc < press_cyc + 2000) begin
      @(negedge clk);
      pr_cnt += press[0];
      if (long_press[0]) begin
        lp_cnt++;
        lp_cyc = cyc;
      end
      if (repeat_pulse[0]) begin
        rp_cnt++;
`ifdef BTN_DEBOUNCE_REPEAT_EN
        want = (last_rp == 0) ? lp_cyc + 40 : last_rp + 40;
        total++;
        if (cyc !== want) begin
          bad++;
          $display("FAIL repeat_spacing: got cycle %0d want %0d", cyc, want);
        end
`endif
        last_rp = cyc;
      end
    end
    total++;
    if (lp_cnt !== 1) begin
      bad++;
      $display("FAIL long_count: got %0d want 1", lp_cnt);
    end
    total++;
    if (lp_cyc - press_cyc < 90 || lp_cyc - press_cyc > 110) begin
      bad++;
      $display("FAIL long_delay: got %0d want 90..110", lp_cyc - press_cyc);
    end
    total++;
    if (pr_cnt !== 0) begin
      bad++;
      $display("FAIL hold_no_press: got %0d want 0", pr_cnt);
    end
`ifdef BTN_DEBOUNCE_REPEAT_EN
    total++;
    if (rp_cnt < 40) begin
      bad++;
      $display("FAIL repeat_count: got %0d want >=40", rp_cnt);
    end
`else
    total++;
    if (rp_cnt !== 0) begin
      bad++;
      $display("FAIL repeat_disabled: got %0d want 0", rp_cnt);
    end
`endif
  endtask

  task automatic test_release();
    int start;
    int first;
    int cnt;
    int after;
    int lp_at;
    int pc_at;
    start = cyc;
    first = 0;
    cnt = 0;
    after = 0;
    btn[0] = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (release_pulse[0]) begin
        cnt++;
        if (first == 0) first = cyc - start;
        total++;
        if (press[0] !== 1'b0 || level[0] !== 1'b0) begin
          bad++;
          $display("FAIL release_exclusive: press=%b level=%b want 0/0", press[0], level[0]);
        end
      end
      if (first != 0) after += long_press[0] + repeat_pulse[0] + press[0];
    end
    total++;
    if (cnt !== 1) begin
      bad++;
      $display("FAIL release_count: got %0d want 1", cnt);
    end
    total++;
    if (first < 21 || first > 33) begin
      bad++;
      $display("FAIL release_latency: got %0d want 21..33", first);
    end
    total++;
    if (after !== 0) begin
      bad++;
      $display("FAIL release_quiet: got %0d pulses want 0", after);
    end
    // Re-press: hold count must restart from zero.
    lp_at = 0;
    pc_at = 0;
    btn[0] = 1'b0;
    for (int k = 0; k < 200 && lp_at == 0; k++) begin
      @(negedge clk);
      if (press[0] && pc_at == 0) pc_at = cyc;
      if (long_press[0]) lp_at = cyc;
    end
    total++;
    if (pc_at == 0 || lp_at - pc_at < 90 || lp_at - pc_at > 110) begin
      bad++;
      $display("FAIL repress_long_delay: press@%0d long@%0d want gap 90..110", pc_at, lp_at);
    end
    btn[0] = 1'b1;
    repeat (60) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int nz;
    logic [N-1:0] seen;
    int pc0;
    int bad1;
    nz = 0;
    seen = 2'b00;
    btn = 2'b00;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (press !== 2'b00) begin nz++; seen = press; end
    end
    total++;
    if (nz !== 1 || seen !== 2'b11) begin
      bad++;
      $display("FAIL simul_press: events=%0d value=%b want 1/11", nz, seen);
    end
    nz = 0;
    seen = 2'b00;
    btn = 2'b11;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (release_pulse !== 2'b00) begin nz++; seen = release_pulse; end
    end
    total++;
    if (nz !== 1 || seen !== 2'b11) begin
      bad++;
      $display("FAIL simul_release: events=%0d value=%b want 1/11", nz, seen);
    end
    // Channel 1 bounces every 7 cycles while channel 0 is pressed cleanly.
    pc0 = 0;
    bad1 = 0;
    btn[0] = 1'b0;
    for (int k = 0; k < 84; k++) begin
      if (k % 7 == 0) btn[1] = ~btn[1];
      @(negedge clk);
      pc0 += press[0];
      bad1 += press[1] + level[1];
    end
    btn[1] = 1'b1;
    total++;
    if (pc0 !== 1 || level[0] !== 1'b1) begin
      bad++;
      $display("FAIL ch0_under_bounce: presses=%0d level=%b want 1/1", pc0, level[0]);
    end
    total++;
    if (bad1 !== 0) begin
      bad++;
      $display("FAIL ch1_bounce_reject: got %0d want 0", bad1);
    end
    btn[0] = 1'b1;
    repeat (60) @(negedge clk);
  endtask

  task automatic test_reset_mid_hold();
    int lp_at;
    int start;
    int first;
    int cnt;
    int leak;
    lp_at = 0;
    btn[0] = 1'b0;
    for (int k = 0; k < 200 && lp_at == 0; k++) begin
      @(negedge clk);
      if (long_press[0]) lp_at = cyc;
    end
    repeat (50) @(negedge clk);
    total++;
    if (lp_at == 0 || level[0] !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_hold: long@%0d level=%b want long seen/1", lp_at, level[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({level, press, release_pulse, long_press, repeat_pulse} !== 10'd0) begin
      bad++;
      $display("FAIL async_reset: got %b want 0", {level, press, release_pulse, long_press, repeat_pulse});
    end
    leak = 0;
    repeat (3) begin
      @(negedge clk);
      leak += (({level, press, release_pulse, long_press, repeat_pulse} != 10'd0) ? 1 : 0);
    end
    total++;
    if (leak !== 0) begin
      bad++;
      $display("FAIL reset_held_quiet: got %0d active samples want 0", leak);
    end
    rst_n = 1'b1;
    start = cyc;
    first = 0;
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (press[0]) begin
        cnt++;
        if (first == 0) first = cyc - start;
      end
    end
    total++;
    if (cnt !== 1 || first < 21 || first > 33) begin
      bad++;
      $display("FAIL press_after_reset: count=%0d latency=%0d want 1 and 21..33", cnt, first);
    end
    btn[0] = 1'b1;
    repeat (60) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_clean_press();
    test_long_hold();
    test_release();
    test_simultaneous();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
